// File: rtl/ppgen_pipe.sv
// Two-stage valid/ready pipeline producing the 12x12 Baugh-Wooley partial-product array.
// Optional PPGEN_ZERO_FLAG_EN adds out_zero, flagging a zero operand alongside each array.
module ppgen_pipe #(
    parameter int W     = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W*W-1:0]   out_pp,
`ifdef PPGEN_ZERO_FLAG_EN
    output logic             out_zero,
`endif
    output logic [CNT_W-1:0] txn_cnt
);

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_a_q, s1_a_d;
    logic [W-1:0]     s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [W*W-1:0]   s2_pp_q, s2_pp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s2_take;
    logic             s1_take;
    logic             in_fire;
    logic [W*W-1:0]   pp_gen;

`ifdef PPGEN_ZERO_FLAG_EN
    logic s2_zero_q, s2_zero_d;
`endif

    // Baugh-Wooley array from the stage-1 operands; only the sign row/column
    // cross terms are inverted, the sign*sign term stays true.
    always_comb begin
        pp_gen = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                pp_gen[W*i+j] = (s1_a_q[j] & s1_b_q[i]) ^ ((i == W-1) != (j == W-1));
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        s2_take    = !s2_valid_q || out_ready;
        s1_take    = !s1_valid_q || s2_take;
        in_fire    = in_valid && s1_take;

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_pp_d    = s2_pp_q;
`ifdef PPGEN_ZERO_FLAG_EN
        s2_zero_d  = s2_zero_q;
`endif

        if (s1_take) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d = in_a;
                s1_b_d = in_b;
            end
        end

        // Stage 2 keeps its old payload when it loads a bubble; out_valid gates it.
        if (s2_take) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_pp_d = pp_gen;
`ifdef PPGEN_ZERO_FLAG_EN
                s2_zero_d = (s1_a_q == '0) || (s1_b_q == '0);
`endif
            end
        end

        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, in_fire};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_pp_q    <= '0;
            cnt_q      <= '0;
`ifdef PPGEN_ZERO_FLAG_EN
            s2_zero_q  <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_pp_q    <= s2_pp_d;
            cnt_q      <= cnt_d;
`ifdef PPGEN_ZERO_FLAG_EN
            s2_zero_q  <= s2_zero_d;
`endif
        end
    end

    // NOTE: the stage-1 operand registers carry no reset; s1_valid_q qualifies them.
    always_ff @(posedge clk) begin
        s1_a_q <= s1_a_d;
        s1_b_q <= s1_b_d;
    end

    assign in_ready  = s1_take;
    assign out_valid = s2_valid_q;
    assign out_pp    = s2_pp_q;
    assign txn_cnt   = cnt_q;
`ifdef PPGEN_ZERO_FLAG_EN
    assign out_zero  = s2_zero_q;
`endif

endmodule

// File: tb/tb_ppgen_pipe.sv
// Scoreboard bench for ppgen_pipe: expected arrays and tree products are queued on
// input transfer and compared on output transfer; handshake follows a stage model.
module tb_ppgen_pipe;

    localparam int W     = 12;
    localparam int CNT_W = 16;

    typedef struct {
        logic [W*W-1:0] pp;
        logic [2*W-1:0] prod;
        logic           zero;
    } sb_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [W*W-1:0]   out_pp;
    logic [CNT_W-1:0] txn_cnt;
`ifdef PPGEN_ZERO_FLAG_EN
    logic             out_zero;
`endif

    sb_t              sb[$];
    int               n_cmp = 0;
    int               n_mis = 0;
    logic             m_s1v = 1'b0;
    logic             m_s2v = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             last_in_fire;

    ppgen_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pp   (out_pp),
`ifdef PPGEN_ZERO_FLAG_EN
        .out_zero (out_zero),
`endif
        .txn_cnt  (txn_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "simulation time limit");
    end

    // Row-wise construction: true AND row, then flip the bits that the sign rule inverts.
    function automatic logic [W*W-1:0] pp_model(logic [W-1:0] a, logic [W-1:0] b);
        logic [W*W-1:0] pp;
        logic [W-1:0]   row;
        pp = '0;
        for (int i = 0; i < W; i++) begin
            row = a & {W{b[i]}};
            if (i < W-1) row = row ^ (12'h001 << (W-1));
            else         row = row ^ {1'b0, {(W-1){1'b1}}};
            pp[W*i +: W] = row;
        end
        return pp;
    endfunction

    function automatic logic [2*W-1:0] prod_model(logic [W-1:0] a, logic [W-1:0] b);
        int sa;
        int sbv;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        return 24'(sa * sbv);
    endfunction

    // What the compressor tree computes: weighted bit sum plus the two correction ones.
    function automatic logic [2*W-1:0] tree_sum(logic [W*W-1:0] pp);
        logic [2*W-1:0] s;
        s = 24'h001000 + 24'h800000;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (pp[W*i+j]) s = s + (24'h000001 << (i + j));
        return s;
    endfunction

    task automatic chk(string tag, logic [W*W-1:0] obs, logic [W*W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check handshake at negedge, account transfers, advance to posedge+1.
    task automatic step();
        logic exp_in_ready;
        logic s2_take;
        sb_t  e;
        @(negedge clk);
        s2_take      = !m_s2v || out_ready;
        exp_in_ready = !m_s1v || s2_take;
        chk("in_ready", in_ready, exp_in_ready);
        chk("out_valid", out_valid, m_s2v);
        last_in_fire = 1'b0;
        if (rst) begin
            m_s1v   = 1'b0;
            m_s2v   = 1'b0;
            exp_cnt = '0;
            sb.delete();
        end else begin
            if (m_s2v && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("pp", out_pp, e.pp);
                    chk("tree_prod", tree_sum(out_pp), e.prod);
`ifdef PPGEN_ZERO_FLAG_EN
                    chk("zero", out_zero, e.zero);
`endif
                end
            end
            if (in_valid && exp_in_ready) begin
                sb.push_back('{pp: pp_model(in_a, in_b), prod: prod_model(in_a, in_b),
                               zero: (in_a == '0) || (in_b == '0)});
                exp_cnt      = exp_cnt + 1'b1;
                last_in_fire = 1'b1;
            end
            if (s2_take)      m_s2v = m_s1v;
            if (exp_in_ready) m_s1v = in_valid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_pair();
        logic [W-1:0] corner[4];
        corner = '{12'h000, 12'h800, 12'h7FF, 12'hFFF};
        in_a = ($urandom_range(7) == 0) ? corner[$urandom_range(3)] : W'($urandom);
        in_b = ($urandom_range(7) == 0) ? corner[$urandom_range(3)] : W'($urandom);
    endtask

    task automatic send_one(logic [W-1:0] a, logic [W-1:0] b);
        int cyc = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        do begin
            step();
            cyc++;
        end while (!last_in_fire && cyc < 50);
        chk("send_timeout", 1'(last_in_fire), 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain(int max_cycles);
        int cyc = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && cyc < max_cycles) begin
            step();
            cyc++;
        end
        chk("drain_timeout", 1'(sb.size() == 0), 1'b1);
    endtask

    task automatic drive_pairs(int n, int ready_pct, int max_cycles, bit keep_pending);
        int sent = 0;
        int cyc  = 0;
        if (!keep_pending) new_pair();
        in_valid = 1'b1;
        while ((sent < n || sb.size() != 0) && cyc < max_cycles) begin
            out_ready = ($urandom_range(99) < ready_pct);
            step();
            cyc++;
            if (last_in_fire) begin
                sent++;
                if (sent < n) new_pair();
                else          in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("stream_timeout", 1'(cyc < max_cycles), 1'b1);
    endtask

    initial begin
        logic [W*W-1:0] t1_pp;
        int             fires;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pp", out_pp, '0);
        chk("rst_txn_cnt", txn_cnt, '0);
        chk("rst_in_ready", in_ready, 1'b1);

        // 3 * 5: two true rows, sign-column ones elsewhere, inverted sign row.
        for (int i = 0; i < W; i++)
            t1_pp[W*i +: W] = (i == 0 || i == 2) ? 12'h803 : (i == W-1) ? 12'h7FF : 12'h800;
        out_ready = 1'b1;
        send_one(12'h003, 12'h005);
        chk("t1_valid_after_accept", out_valid, 1'b0);
        step();
        chk("t1_valid_next_edge", out_valid, 1'b1);
        chk("t1_pp_const", out_pp, t1_pp);
        chk("t1_tree", tree_sum(out_pp), 24'h00000F);
        drain(10);
        chk("t1_txn_cnt", txn_cnt, 16'd1);

        // Most negative squared: the one product whose true result needs bit 22.
        send_one(12'h800, 12'h800);
        step();
        chk("t2_out_valid", out_valid, 1'b1);
        chk("t2_tree", tree_sum(out_pp), 24'h400000);
        drain(10);

        // Backpressure: exactly two pairs fit, then in_ready drops and stays low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        new_pair();
        fires = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (last_in_fire) begin
                fires++;
                new_pair();
            end
        end
        chk("t3_fill_count", 32'(fires), 32'd2);
        chk("t3_in_ready_full", in_ready, 1'b0);
        chk("t3_out_valid_full", out_valid, 1'b1);
        drive_pairs(6, 100, 100, 1'b1);
        chk("t3_txn_cnt", txn_cnt, 16'd10);

        // Long random stream with random sink stalls.
        drive_pairs(10000, 60, 60000, 1'b0);
        chk("t4_txn_cnt", txn_cnt, 16'd10010);
        chk("t4_txn_model", txn_cnt, exp_cnt);

        // Reset with both stages full: held pairs are discarded.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        new_pair();
        step();
        new_pair();
        step();
        chk("t5_full_out_valid", out_valid, 1'b1);
        chk("t5_full_in_ready", in_ready, 1'b0);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_in_ready", in_ready, 1'b1);
        chk("t5_txn_cnt", txn_cnt, '0);
        chk("t5_out_pp", out_pp, '0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        chk("t5_no_ghost", out_valid, 1'b0);

`ifdef PPGEN_ZERO_FLAG_EN
        send_one(12'h000, 12'h123);
        step();
        chk("t6_zero_set", out_zero, 1'b1);
        drain(10);
        send_one(12'h001, 12'h001);
        step();
        chk("t6_zero_clear", out_zero, 1'b0);
        drain(10);
`endif

        // Short mixed stream after reset to confirm normal operation resumes.
        drive_pairs(40, 50, 400, 1'b0);
        chk("end_txn_cnt", txn_cnt, exp_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
